// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared types and constants for the ALU command issuer.
//                ALU_N fixes the operand/result width carried in the
//                command and response records; it must match the N
//                parameter of alu_cmd_issuer.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   localparam int ALU_N = 16;

   localparam logic OP_ADD      = 1'b0;
   localparam logic OP_MULTIPLY = 1'b1;

   typedef struct packed {
      logic             op;
      logic [ALU_N-1:0] a;
      logic [ALU_N-1:0] b;
   } alu_cmd_t;

   typedef struct packed {
      logic             op;
      logic [ALU_N-1:0] result;
      logic             ov;
      logic             uv;
   } alu_rsp_t;

   // Clamp a result to the signed range limits when the ALU flags a wrap.
   function automatic logic [ALU_N-1:0] sat_result(input logic [ALU_N-1:0] raw,
                                                   input logic             ov,
                                                   input logic             uv);
      logic [ALU_N-1:0] v;
      v = raw;
      if (ov)
         v = {1'b0, {(ALU_N-1){1'b1}}};
      else if (uv)
         v = {1'b1, {(ALU_N-1){1'b0}}};
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_fifo
//  Description : Synchronous command FIFO. A push is refused while full, a
//                pop is ignored while empty; pointers wrap modulo DEPTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_push,
   input  alu_cmd_t                     i_data,
   input  logic                         i_pop,
   output alu_cmd_t                     o_data,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   alu_cmd_t          r_mem [DEPTH];
   logic [AW-1:0]     r_wr_ptr;
   logic [AW-1:0]     r_rd_ptr;
   logic [LW-1:0]     r_level;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_level == LW'(DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_data    = r_mem[r_rd_ptr];
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;

   // Pointer and occupancy tracking; DEPTH is a power of two so pointers wrap naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cmd_issuer
//  Description : Command front-end and response collector for a registered
//                (1-cycle) add/multiply ALU. Commands are queued, issued at
//                most one per cycle under a 2-credit rule, and results are
//                captured into a 2-entry valid/ready response buffer with
//                sticky overflow/underflow status.
//  Config      : ALU_ISSUER_SAT_EN - saturate captured results on ov/uv.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int N     = 16,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic                         cmd_op,
   input  logic [N-1:0]                 cmd_a,
   input  logic [N-1:0]                 cmd_b,
   output logic                         alu_op_sel,
   output logic [N-1:0]                 alu_a,
   output logic [N-1:0]                 alu_b,
   input  logic [N-1:0]                 alu_result,
   input  logic                         alu_ov,
   input  logic                         alu_uv,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_op,
   output logic [N-1:0]                 rsp_result,
   output logic                         rsp_ov,
   output logic                         rsp_uv,
   input  logic                         clr_sticky,
   output logic                         sticky_ov,
   output logic                         sticky_uv,
   output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

   alu_cmd_t      w_push_data;
   alu_cmd_t      w_head;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic          w_issue;
   logic          w_rsp_pop;
   logic [2:0]    w_credit_used;
   logic [N-1:0]  w_cap_result;
   alu_rsp_t      w_cap_entry;

   logic          r_in_flight;
   logic          r_op_pipe;
   alu_rsp_t      r_rsp_mem [2];
   logic          r_rsp_wr;
   logic          r_rsp_rd;
   logic [1:0]    r_rsp_cnt;
   logic          r_sticky_ov;
   logic          r_sticky_uv;

   assign w_push_data = '{op: cmd_op, a: cmd_a, b: cmd_b};
   assign cmd_ready   = ~w_fifo_full;

   alu_cmd_fifo #(
      .DEPTH   (DEPTH)
   ) u_cmd_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (cmd_valid),
      .i_data  (w_push_data),
      .i_pop   (w_issue),
      .o_data  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_level (fifo_level)
   );

   // Credits: buffered responses plus the one in the ALU, minus the one leaving this cycle.
   assign w_rsp_pop     = rsp_valid & rsp_ready;
   assign w_credit_used = 3'(r_rsp_cnt) + 3'(r_in_flight) - 3'(w_rsp_pop);
   assign w_issue       = ~w_fifo_empty & (w_credit_used < 3'd2);

   // Drive the FIFO head onto the ALU when issuing; otherwise hold idle operands at zero.
   always_comb begin
      alu_op_sel = OP_ADD;
      alu_a      = '0;
      alu_b      = '0;
      if (w_issue) begin
         alu_op_sel = w_head.op;
         alu_a      = w_head.a;
         alu_b      = w_head.b;
      end
   end

   // Track the single ALU pipeline stage and the op travelling with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_in_flight <= 1'b0;
         r_op_pipe   <= 1'b0;
      end else begin
         r_in_flight <= w_issue;
         r_op_pipe   <= w_issue ? w_head.op : 1'b0;
      end
   end

`ifdef ALU_ISSUER_SAT_EN
   assign w_cap_result = sat_result(alu_result, alu_ov, alu_uv);
`else
   assign w_cap_result = alu_result;
`endif

   assign w_cap_entry = '{op: r_op_pipe, result: w_cap_result, ov: alu_ov, uv: alu_uv};

   // Two-entry response buffer; the credit rule prevents a push into a full buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_mem[0] <= '0;
         r_rsp_mem[1] <= '0;
         r_rsp_wr     <= 1'b0;
         r_rsp_rd     <= 1'b0;
         r_rsp_cnt    <= 2'd0;
      end else begin
         if (r_in_flight) begin
            r_rsp_mem[r_rsp_wr] <= w_cap_entry;
            r_rsp_wr            <= ~r_rsp_wr;
         end
         if (w_rsp_pop)
            r_rsp_rd <= ~r_rsp_rd;
         case ({r_in_flight, w_rsp_pop})
            2'b10:   r_rsp_cnt <= r_rsp_cnt + 2'd1;
            2'b01:   r_rsp_cnt <= r_rsp_cnt - 2'd1;
            default: r_rsp_cnt <= r_rsp_cnt;
         endcase
      end
   end

   assign rsp_valid  = (r_rsp_cnt != 2'd0);
   assign rsp_op     = r_rsp_mem[r_rsp_rd].op;
   assign rsp_result = r_rsp_mem[r_rsp_rd].result;
   assign rsp_ov     = r_rsp_mem[r_rsp_rd].ov;
   assign rsp_uv     = r_rsp_mem[r_rsp_rd].uv;

   // Sticky status: a flagged capture wins over a simultaneous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sticky_ov <= 1'b0;
         r_sticky_uv <= 1'b0;
      end else begin
         if (r_in_flight & alu_ov)
            r_sticky_ov <= 1'b1;
         else if (clr_sticky)
            r_sticky_ov <= 1'b0;
         if (r_in_flight & alu_uv)
            r_sticky_uv <= 1'b1;
         else if (clr_sticky)
            r_sticky_uv <= 1'b0;
      end
   end

   assign sticky_ov = r_sticky_ov;
   assign sticky_uv = r_sticky_uv;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_issuer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_cmd_issuer
//  Description : Self-checking bench for alu_cmd_issuer with a behavioural
//                1-cycle registered add/multiply ALU attached.
//  Config      : ALU_ISSUER_SAT_EN selects saturated expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_issuer;

   localparam int N     = 16;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_op;
   logic [N-1:0]  cmd_a;
   logic [N-1:0]  cmd_b;
   logic          alu_op_sel;
   logic [N-1:0]  alu_a;
   logic [N-1:0]  alu_b;
   logic [N-1:0]  alu_result = '0;
   logic          alu_ov = 1'b0;
   logic          alu_uv = 1'b0;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_op;
   logic [N-1:0]  rsp_result;
   logic          rsp_ov;
   logic          rsp_uv;
   logic          clr_sticky;
   logic          sticky_ov;
   logic          sticky_uv;
   logic [2:0]    fifo_level;

   int            checks = 0;
   int            errors = 0;
   logic [18:0]   exp_q[$];

   alu_cmd_issuer #(.N(N), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_a      (cmd_a),
      .cmd_b      (cmd_b),
      .alu_op_sel (alu_op_sel),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_result (alu_result),
      .alu_ov     (alu_ov),
      .alu_uv     (alu_uv),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_op     (rsp_op),
      .rsp_result (rsp_result),
      .rsp_ov     (rsp_ov),
      .rsp_uv     (rsp_uv),
      .clr_sticky (clr_sticky),
      .sticky_ov  (sticky_ov),
      .sticky_uv  (sticky_uv),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   // Signed arithmetic on plain integers: returns {wrapped result, ov, uv}.
   function automatic logic [17:0] alu_ref(input logic op, input logic [15:0] a, input logic [15:0] b);
      int sa, sb, r;
      logic [15:0] res;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      r   = op ? sa * sb : sa + sb;
      res = r[15:0];
      return {res, (r > 32767), (r < -32768)};
   endfunction

   // Expected response record {op, result, ov, uv} for one command.
   function automatic logic [18:0] expect_rsp(input logic op, input logic [15:0] a, input logic [15:0] b);
      logic [17:0] raw;
      logic [15:0] res;
      raw = alu_ref(op, a, b);
      res = raw[17:2];
`ifdef ALU_ISSUER_SAT_EN
      if (raw[1])
         res = 16'h7FFF;
      else if (raw[0])
         res = 16'h8000;
`endif
      return {op, res, raw[1], raw[0]};
   endfunction

   // Behavioural registered ALU.
   always @(posedge clk)
      {alu_result, alu_ov, alu_uv} <= alu_ref(alu_op_sel, alu_a, alu_b);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: handshakes are stable at the falling edge and take effect at the next rising edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            check("rsp_order", {13'd0, rsp_op, rsp_result, rsp_ov, rsp_uv},
                  (exp_q.size() != 0) ? {13'd0, exp_q[0]} : 32'hDEAD_BEEF);
            if (exp_q.size() != 0)
               void'(exp_q.pop_front());
         end
         if (cmd_valid && cmd_ready)
            exp_q.push_back(expect_rsp(cmd_op, cmd_a, cmd_b));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic op, input logic [15:0] a, input logic [15:0] b);
      int n;
      n         = 0;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100)
         check("send_timeout", 32'(n), 32'd0);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50)
         check("rsp_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc, vcnt, rises;
      logic prev;

      rst_n      = 1'b0;
      cmd_valid  = 1'b0;
      cmd_op     = 1'b0;
      cmd_a      = '0;
      cmd_b      = '0;
      rsp_ready  = 1'b0;
      clr_sticky = 1'b0;
      tick();
      tick();
      // Reset state
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_fifo_level", fifo_level, 0);
      check("rst_sticky", {sticky_ov, sticky_uv}, 0);
      check("rst_alu", {alu_op_sel, alu_a, alu_b}, 0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      tick();

      // 1: add 3+4 with two-cycle latency
      cmd_valid = 1'b1; cmd_op = 1'b0; cmd_a = 16'h0003; cmd_b = 16'h0004;
      tick();
      cmd_valid = 1'b0;
      check("t1_issue_a", alu_a, 16'h0003);
      check("t1_lat_e0", rsp_valid, 0);
      tick();
      check("t1_lat_e1", rsp_valid, 0);
      tick();
      check("t1_lat_e2", rsp_valid, 1);
      check("t1_result", {rsp_result, rsp_ov, rsp_uv}, {16'h0007, 2'b00});

      // 2: overflow
      send(1'b0, 16'h7FFF, 16'h0001);
      wait_rsp();
      check("t2_ov", rsp_ov, 1);
`ifdef ALU_ISSUER_SAT_EN
      check("t2_result", rsp_result, 16'h7FFF);
`else
      check("t2_result", rsp_result, 16'h8000);
`endif
      check("t2_sticky_ov", sticky_ov, 1);

      // 3: underflow
      send(1'b0, 16'h8000, 16'hFFFF);
      wait_rsp();
      check("t3_uv", rsp_uv, 1);
`ifdef ALU_ISSUER_SAT_EN
      check("t3_result", rsp_result, 16'h8000);
`else
      check("t3_result", rsp_result, 16'h7FFF);
`endif
      check("t3_sticky_uv", sticky_uv, 1);
      tick();
      tick();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("clr_sticky", {sticky_ov, sticky_uv}, 0);

      // 4: backpressure fills response buffer, pipeline and FIFO
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      acc = 0;
      for (int i = 0; i < 12; i++) begin
         cmd_op = 1'($urandom);
         cmd_a  = 16'($urandom);
         cmd_b  = 16'($urandom);
         if (cmd_ready)
            acc++;
         tick();
      end
      cmd_valid = 1'b0;
      check("t4_accepted", 32'(acc), 6);
      check("t4_cmd_ready", cmd_ready, 0);
      check("t4_fifo_level", fifo_level, 4);
      rsp_ready = 1'b1;
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid)
            vcnt++;
         tick();
      end
      check("t4_drain_b2b", 32'(vcnt), 6);
      check("t4_empty", 32'(exp_q.size()), 0);

      // 5: interleaved mul/add stream without gaps
      tick();
      vcnt  = 0;
      rises = 0;
      prev  = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (i < 10) begin
            cmd_valid = 1'b1;
            cmd_op    = (i % 2 == 0) ? 1'b1 : 1'b0;
            cmd_a     = (i % 2 == 0) ? 16'h0002 : 16'h0001;
            cmd_b     = (i % 2 == 0) ? 16'h0003 : 16'h0001;
            check("t5_ready", cmd_ready, 1);
         end else begin
            cmd_valid = 1'b0;
         end
         if (rsp_valid) begin
            vcnt++;
            if (!prev)
               rises++;
         end
         if (rsp_valid && vcnt == 1)
            check("t5_first", rsp_result, 16'h0006);
         if (rsp_valid && vcnt == 2)
            check("t5_second", rsp_result, 16'h0002);
         prev = rsp_valid;
         tick();
      end
      check("t5_count", 32'(vcnt), 10);
      check("t5_no_gap", 32'(rises), 1);

      // Randomized traffic against the scoreboard
      for (int i = 0; i < 300; i++) begin
         cmd_valid = 1'($urandom);
         cmd_op    = 1'($urandom);
         cmd_a     = ($urandom_range(0, 3) == 0) ? 16'h7FFF : 16'($urandom);
         cmd_b     = 16'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      repeat (10) tick();
      check("rand_drained", 32'(exp_q.size()), 0);
      check("rand_level", fifo_level, 0);
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;

      // 6: reset mid-operation
      rsp_ready = 1'b0;
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_op = 1'b0;
         cmd_a  = (i == 0) ? 16'h7FFF : 16'(i);
         cmd_b  = 16'h0001;
         tick();
      end
      cmd_valid = 1'b0;
      check("t6_level_pre", fifo_level, 3);
      check("t6_sticky_pre", sticky_ov, 1);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      check("t6_level_post", fifo_level, 0);
      check("t6_sticky_post", {sticky_ov, sticky_uv}, 0);
      vcnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (rsp_valid)
            vcnt++;
         tick();
      end
      check("t6_no_stale", 32'(vcnt), 0);
      send(1'b0, 16'h1234, 16'h0101);
      wait_rsp();
      check("t6_first_new", rsp_result, 16'h1335);
      tick();
      tick();

      // clear coinciding with an ov capture: set wins
      check("t6_sticky_idle", sticky_ov, 0);
      send(1'b0, 16'h7FFF, 16'h0001);
      tick();
      clr_sticky = 1'b1;
      tick();
      clr_sticky = 1'b0;
      check("t6_clr_vs_set", sticky_ov, 1);
      check("t6_rsp_valid", rsp_valid, 1);
      repeat (4) tick();
      check("final_drained", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
